// File: rtl/shift_normalizer_pkg.sv
// Shared types and helpers for the sequential left-normalizer.
package shift_normalizer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Widest word stage_zero can inspect; callers zero-extend into it.
    localparam int MAX_W = 64;

    function automatic int calc_sw(input int width);
        return $clog2(width);
    endfunction

    // True when the top 2^k bits of a width-bit word are all zero.
    function automatic logic stage_zero(input logic [MAX_W-1:0] word,
                                        input int               width,
                                        input int               k);
        logic allZero;
        allZero = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            if ((i >= width - (1 << k)) && (i < width) && word[i]) begin
                allZero = 1'b0;
            end
        end
        return allZero;
    endfunction

endpackage

// File: rtl/normalize_stage.sv
// One binary-search normalization stage: shifts left by 2^k when the top 2^k bits are clear.
module normalize_stage
    import shift_normalizer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SW    = calc_sw(WIDTH)
) (
    input  logic [WIDTH-1:0] i_word,
    input  logic [SW-1:0]    i_k,
    output logic [WIDTH-1:0] o_word,
    output logic             o_taken
);

    logic [SW-1:0] w_dist;

    assign o_taken = stage_zero(MAX_W'(i_word), WIDTH, int'(i_k));
    assign w_dist  = SW'(1) << i_k;
    assign o_word  = o_taken ? (i_word << w_dist) : i_word;

endmodule

// File: rtl/shift_normalizer.sv
// Sequential left-normalizer: one stage per clock, valid/ready on both sides.
module shift_normalizer
    import shift_normalizer_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SW    = calc_sw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [SW-1:0]    shift_amount,
    output logic             zero
);

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [SW-1:0]    r_amount;
    logic [SW-1:0]    r_k;
    logic             r_zero;
    logic             r_outValid;

    logic [WIDTH-1:0] w_stageWord;
    logic             w_stageTaken;

    normalize_stage #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_stage (
        .i_word  (r_work),
        .i_k     (r_k),
        .o_word  (w_stageWord),
        .o_taken (w_stageTaken)
    );

    // DONE spends one cycle raising out_valid so results appear SW+1 cycles after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_amount   <= '0;
            r_k        <= SW'(SW - 1);
            r_zero     <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work   <= data_in;
                        r_amount <= '0;
                        r_zero   <= (data_in == '0);
                        r_k      <= SW'(SW - 1);
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work <= w_stageWord;
                    if (w_stageTaken) begin
                        r_amount[r_k] <= 1'b1;
                    end
                    if (r_k == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k - SW'(1);
                    end
                end
                DONE: begin
                    if (!r_outValid) begin
                        r_outValid <= 1'b1;
                    end else if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = r_outValid;
    assign data_out     = r_work;
    assign shift_amount = r_amount;
    assign zero         = r_zero;

endmodule
